// File: rtl/output_display_pkg.sv
// Shared definitions for the output display: segment codes, FSM states and
// the double-dabble nibble correction.
package output_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  localparam int NUM_DIGITS  = 4;
  localparam int NUM_NUMERIC = 3;
  localparam int SHIFT_STEPS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Double-dabble correction applied to each BCD nibble before a shift.
  function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/output_display_seg7_decode.sv
// BCD digit to 7-segment pattern {g,f,e,d,c,b,a}, active-high; blank
// forces all segments off.
module output_display_seg7_decode
  import output_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/output_display.sv
// Shows the CPU output register on a 4-digit multiplexed 7-segment display,
// converting to decimal with a sequential double-dabble engine.
module output_display
  import output_display_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] data_i,
  input  logic       signed_mode,
  output logic [6:0] seg,
  output logic [3:0] digit_en,
  output logic       busy
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  state_t        state_reg;
  logic [7:0]    last_val_reg;
  logic          last_mode_reg;
  logic [7:0]    mag_reg;
  logic [11:0]   bcd_reg;
  logic          neg_reg;
  logic [2:0]    cnt_reg;
  logic          busy_reg;

  logic [3:0]    hund_reg;
  logic [3:0]    tens_reg;
  logic [3:0]    ones_reg;
  logic          sign_reg;

  logic [PW-1:0] presc_reg;
  logic [1:0]    scan_idx_reg;
  logic [1:0]    scan_idx_next;
  logic [3:0]    digit_en_reg;
  logic [6:0]    seg_reg;

  logic [11:0]   bcd_adj;
  logic [19:0]   dd_shift;
  logic          input_changed;
  logic          presc_term;

  logic [3:0]    digit_val   [NUM_NUMERIC];
  logic          digit_blank [NUM_NUMERIC];
  logic [6:0]    digit_seg   [NUM_DIGITS];

  genvar gi;

  // Per-nibble correction, then one left shift of the combined {bcd,mag}.
  generate
    for (gi = 0; gi < NUM_NUMERIC; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = bcd_adjust(bcd_reg[gi*4 +: 4]);
    end
  endgenerate

  assign dd_shift      = {bcd_adj, mag_reg} << 1;
  assign input_changed = ({data_i, signed_mode} != {last_val_reg, last_mode_reg});

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg     <= ST_IDLE;
      last_val_reg  <= 8'd0;
      last_mode_reg <= 1'b0;
      mag_reg       <= 8'd0;
      bcd_reg       <= 12'd0;
      neg_reg       <= 1'b0;
      cnt_reg       <= 3'd0;
      busy_reg      <= 1'b0;
      hund_reg      <= 4'd0;
      tens_reg      <= 4'd0;
      ones_reg      <= 4'd0;
      sign_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (input_changed) begin
            last_val_reg  <= data_i;
            last_mode_reg <= signed_mode;
            mag_reg       <= (signed_mode & data_i[7]) ? (~data_i + 8'd1) : data_i;
            neg_reg       <= signed_mode & data_i[7];
            bcd_reg       <= 12'd0;
            cnt_reg       <= 3'd0;
            busy_reg      <= 1'b1;
            state_reg     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_reg <= dd_shift[19:8];
          mag_reg <= dd_shift[7:0];
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg == 3'(SHIFT_STEPS - 1)) begin
            state_reg <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          // All four digit registers update on the same edge so the scan
          // never shows a mix of old and new digits.
          hund_reg  <= bcd_reg[11:8];
          tens_reg  <= bcd_reg[7:4];
          ones_reg  <= bcd_reg[3:0];
          sign_reg  <= neg_reg;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign digit_val[0]   = ones_reg;
  assign digit_val[1]   = tens_reg;
  assign digit_val[2]   = hund_reg;
  assign digit_blank[0] = 1'b0;
  assign digit_blank[1] = (tens_reg == 4'd0) && (hund_reg == 4'd0);
  assign digit_blank[2] = (hund_reg == 4'd0);

  generate
    for (gi = 0; gi < NUM_NUMERIC; gi++) begin : g_dec
      output_display_seg7_decode u_dec (
        .bcd   (digit_val[gi]),
        .blank (digit_blank[gi]),
        .seg   (digit_seg[gi])
      );
    end
  endgenerate

  assign digit_seg[3] = sign_reg ? SEG_MINUS : SEG_BLANK;

  assign presc_term    = (presc_reg == PW'(SCAN_DIV - 1));
  assign scan_idx_next = presc_term ? scan_idx_reg + 2'd1 : scan_idx_reg;

  // seg follows the index every cycle so freshly committed digits show at once.
  always_ff @(posedge clk) begin
    if (clr) begin
      presc_reg    <= '0;
      scan_idx_reg <= 2'd0;
      digit_en_reg <= 4'b0001;
      seg_reg      <= SEG_0;
    end else begin
      presc_reg    <= presc_term ? '0 : presc_reg + 1'b1;
      scan_idx_reg <= scan_idx_next;
      digit_en_reg <= 4'b0001 << scan_idx_next;
      seg_reg      <= digit_seg[scan_idx_next];
    end
  end

  assign seg      = seg_reg;
  assign digit_en = digit_en_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_output_display.sv
// Randomized self-checking bench for output_display against a decimal
// reference model computed directly from the displayed value.
module tb_output_display;

  localparam int SCAN_DIV = 4;
  localparam logic [6:0] SEG_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] data_i;
  logic       signed_mode;
  logic [6:0] seg;
  logic [3:0] digit_en;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mdl_last_val;
  logic       mdl_last_mode;

  output_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk         (clk),
    .clr         (clr),
    .data_i      (data_i),
    .signed_mode (signed_mode),
    .seg         (seg),
    .digit_en    (digit_en),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected pattern for a slot, from the value's decimal form.
  function automatic logic [6:0] model_seg(input logic [7:0] v, input logic m, input int slot);
    int val, mag;
    val = (m && v >= 8'd128) ? int'(v) - 256 : int'(v);
    mag = (val < 0) ? -val : val;
    case (slot)
      0:       return SEG_TBL[mag % 10];
      1:       return (mag < 10)  ? 7'h00 : SEG_TBL[(mag / 10) % 10];
      2:       return (mag < 100) ? 7'h00 : SEG_TBL[mag / 100];
      default: return (val < 0)   ? 7'h40 : 7'h00;
    endcase
  endfunction

  function automatic int onehot_slot(input logic [3:0] d);
    case (d)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic check_display(input logic [7:0] v, input logic m, input string tag);
    logic [3:0] seen;
    logic [3:0] prev_en;
    int gap, slot;
    bit first_change;
    seen = 4'b0000;
    prev_en = digit_en;
    gap = 0;
    first_change = 1'b1;
    for (int i = 0; i < 4 * SCAN_DIV + 2; i++) begin
      @(negedge clk);
      slot = onehot_slot(digit_en);
      check_val({tag, "/onehot"}, 32'(slot >= 0), 32'd1);
      if (slot >= 0) begin
        seen[slot] = 1'b1;
        check_val({tag, "/seg"}, seg, model_seg(v, m, slot));
      end
      gap++;
      if (digit_en != prev_en) begin
        check_val({tag, "/rotate"}, digit_en, {prev_en[2:0], prev_en[3]});
        if (!first_change) check_val({tag, "/period"}, gap, SCAN_DIV);
        first_change = 1'b0;
        gap = 0;
        prev_en = digit_en;
      end
    end
    check_val({tag, "/slots"}, seen, 4'hF);
  endtask

  task automatic run_conv(input logic [7:0] v, input logic m, input string tag);
    int n;
    bit expect_conv;
    expect_conv = ({v, m} != {mdl_last_val, mdl_last_mode});
    data_i = v;
    signed_mode = m;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    if (expect_conv) begin
      while (busy === 1'b1 && n < 40) begin
        n++;
        @(negedge clk);
      end
      check_val({tag, "/busy_cycles"}, n, 9);
      mdl_last_val = v;
      mdl_last_mode = m;
    end else begin
      check_val({tag, "/noconv_busy"}, busy, 1'b0);
    end
    $display("conv %s: data=%02h signed=%0d busy_cycles=%0d", tag, v, m, n);
    check_display(v, m, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, slot;
    logic [7:0] rv;
    logic rm;

    clr = 1'b1;
    data_i = 8'd0;
    signed_mode = 1'b0;
    mdl_last_val = 8'd0;
    mdl_last_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset/digit_en", digit_en, 4'b0001);
    check_val("reset/seg", seg, 7'h3F);
    check_val("reset/busy", busy, 1'b0);
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("reset/idle_busy", busy, 1'b0);
    end
    $display("reset: digit_en=%b seg=%02h busy=%0d", digit_en, seg, busy);

    run_conv(8'd255,  1'b0, "u255");
    run_conv(8'hFF,   1'b1, "s_minus1");
    run_conv(8'h80,   1'b1, "s_minus128");
    run_conv(8'h80,   1'b0, "u128");
    run_conv(8'd7,    1'b0, "u7");
    run_conv(8'd0,    1'b0, "u0");
    run_conv(8'h05,   1'b0, "u5");
    run_conv(8'h05,   1'b1, "s5_mode");
    run_conv(8'h05,   1'b1, "s5_same");
    run_conv(8'h05,   1'b0, "u5_mode");

    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 3) begin
        rv = mdl_last_val;
        rm = mdl_last_mode;
      end else begin
        rv = 8'($urandom_range(0, 255));
        rm = 1'($urandom_range(0, 1));
      end
      run_conv(rv, rm, $sformatf("rand%0d", i));
    end

    // Input change on the third shift cycle: 10 commits, then 20 follows.
    run_conv(8'd3, 1'b0, "pre_mid");
    data_i = 8'd10;
    signed_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("mid/busy_start", busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    data_i = 8'd20;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_val("mid/first_tail", n, 7);
    @(negedge clk);
    check_val("mid/reconv_busy", busy, 1'b1);
    slot = onehot_slot(digit_en);
    if (slot >= 0) check_val("mid/seg10", seg, model_seg(8'd10, 1'b0, slot));
    else check_val("mid/onehot", digit_en, 4'b0001);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_val("mid/second_busy", n, 9);
    mdl_last_val = 8'd20;
    mdl_last_mode = 1'b0;
    $display("conv mid: data=0a->14 second busy_cycles=%0d", n);
    check_display(8'd20, 1'b0, "mid20");

    // Reset during a shift aborts the conversion and restores the reset pattern.
    data_i = 8'd200;
    @(posedge clk);
    @(negedge clk);
    check_val("abort/busy_start", busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    data_i = 8'd0;
    signed_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("abort/busy", busy, 1'b0);
    check_val("abort/digit_en", digit_en, 4'b0001);
    check_val("abort/seg", seg, 7'h3F);
    clr = 1'b0;
    mdl_last_val = 8'd0;
    mdl_last_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("abort/idle_busy", busy, 1'b0);
    end
    $display("abort: digit_en=%b seg=%02h busy=%0d", digit_en, seg, busy);
    check_display(8'd0, 1'b0, "abort0");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
